instr_prefetch_unit: RTL and testbench

- Initiator side of the latency instruction-memory channel: issues address/valid requests to a fixed-latency instruction ROM and collects its in-order data/valid responses.
- Buffers returned instructions, each paired with its PC, in a small FIFO and hands them to the CPU decode stage over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered instructions and discards responses already in flight.

---
 rtl/instr_prefetch_unit_if.sv | 27 ++
 rtl/instr_prefetch_unit.sv | 114 +++++++++++
 tb/tb_instr_prefetch_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_unit_if.sv
// Bundle of the ROM request/response channel, the decode-side handshake and the redirect inputs.
// master is the prefetch unit's view; slave is the view of the ROM and CPU around it.
interface instr_prefetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] im_addr;
    logic              im_addr_vld;
    logic [DATA_W-1:0] im_data;
    logic              im_data_vld;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_vld;
    logic              instr_rdy;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output im_addr, im_addr_vld, instr, instr_pc, instr_vld,
        input  im_data, im_data_vld, instr_rdy, redirect, redirect_pc
    );

    modport slave (
        input  im_addr, im_addr_vld, instr, instr_pc, instr_vld,
        output im_data, im_data_vld, instr_rdy, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetcher: credit-limited requests to a fixed-latency ROM, a PC-tagged
// fall-through FIFO towards decode, and redirect handling that kills in-flight responses.
module instr_prefetch_unit #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                   clk,
    input logic                   rst,
    instr_prefetch_unit_if.master bus
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] respPc;
    logic [CntW-1:0]   outstanding;
    logic [CntW-1:0]   outstandingNext;
    logic [CntW-1:0]   killCnt;
    logic [CntW-1:0]   fifoCount;
    logic [PtrW-1:0]   wrPtr;
    logic [PtrW-1:0]   rdPtr;
    logic [CntW:0]     inUse;

    logic [DATA_W-1:0] memData [DEPTH];
    logic [ADDR_W-1:0] memPc   [DEPTH];

    logic issue;
    logic accept;
    logic dropResp;
    logic headVld;
    logic pop;

    // Credits come from registered counts only, so a same-cycle pop frees nothing yet.
    assign inUse    = {1'b0, outstanding} + {1'b0, fifoCount};
    assign issue    = rst & ~bus.redirect & (inUse < (CntW + 1)'(DEPTH));
    assign accept   = bus.im_data_vld & ~bus.redirect & (killCnt == '0);
    assign dropResp = bus.im_data_vld & ~bus.redirect & (killCnt != '0);
    assign headVld  = (fifoCount != '0);
    assign pop      = headVld & bus.instr_rdy & ~bus.redirect;

    assign bus.im_addr     = fetchPc;
    assign bus.im_addr_vld = issue;
    assign bus.instr       = memData[rdPtr];
    assign bus.instr_pc    = memPc[rdPtr];
    assign bus.instr_vld   = headVld;

    always_comb begin
        outstandingNext = outstanding;
        if (issue && !bus.im_data_vld) begin
            outstandingNext = outstanding + CntW'(1);
        end else if (!issue && bus.im_data_vld) begin
            outstandingNext = outstanding - CntW'(1);
        end
    end

    function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            outstanding <= '0;
            killCnt     <= '0;
            fifoCount   <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
        end else begin
            outstanding <= outstandingNext;
            if (bus.redirect) begin
                // Everything still in flight after this edge predates the redirect.
                killCnt   <= outstandingNext;
                fetchPc   <= bus.redirect_pc;
                respPc    <= bus.redirect_pc;
                fifoCount <= '0;
                wrPtr     <= '0;
                rdPtr     <= '0;
            end else begin
                if (issue) begin
                    fetchPc <= fetchPc + ADDR_W'(4);
                end
                if (dropResp) begin
                    killCnt <= killCnt - CntW'(1);
                end
                if (accept) begin
                    respPc <= respPc + ADDR_W'(4);
                    wrPtr  <= ptrInc(wrPtr);
                end
                if (pop) begin
                    rdPtr <= ptrInc(rdPtr);
                end
                if (accept && !pop) begin
                    fifoCount <= fifoCount + CntW'(1);
                end else if (!accept && pop) begin
                    fifoCount <= fifoCount - CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            memData[wrPtr] <= bus.im_data;
            memPc[wrPtr]   <= respPc;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) inUse <= (CntW + 1)'(DEPTH));
    assert property (@(posedge clk) disable iff (!rst) killCnt <= outstanding);

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: latency-selectable ROM model, request-address tracker and a
// PC scoreboard refilled whenever reset or redirect is driven.
module tb_instr_prefetch_unit;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   romLat = 1;

    int compared   = 0;
    int mismatched = 0;
    int reqCount   = 0;
    int delivered  = 0;
    int inflight   = 0;
    int expKill    = 0;
    logic [31:0] expReq = RESET_PC;
    logic [31:0] sb [$];
    logic        holdValid = 1'b0;
    logic [31:0] holdPc = '0;

    instr_prefetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_prefetch_unit #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // ROM: a shift pipe of requests, tapped at the selected latency; reset with the DUT.
    logic [3:0]  pipeVld;
    logic [31:0] pipeAddr [4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipeVld <= '0;
        end else begin
            pipeVld     <= {pipeVld[2:0], bus.im_addr_vld};
            pipeAddr[0] <= bus.im_addr;
            for (int i = 1; i < 4; i++) pipeAddr[i] <= pipeAddr[i-1];
        end
    end

    always_comb begin
        bus.im_data_vld = pipeVld[romLat-1];
        bus.im_data     = romWord(pipeAddr[romLat-1]);
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fillSb(input logic [31:0] pc);
        sb.delete();
        for (int i = 0; i < 128; i++) sb.push_back(pc + 32'(4 * i));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.redirect) checkVal("reqOnRedirect", 64'(bus.im_addr_vld), 0);
            if (bus.im_addr_vld) begin
                checkVal("reqAddr", 64'(bus.im_addr), 64'(expReq));
                expReq += 32'd4;
                reqCount++;
                inflight++;
            end
            if (bus.im_data_vld) inflight--;
            if (holdValid) begin
                checkVal("headHoldVld", 64'(bus.instr_vld), 1);
                checkVal("headHoldPc", 64'(bus.instr_pc), 64'(holdPc));
            end
            if (bus.instr_vld && bus.instr_rdy && !bus.redirect) begin
                if (sb.size() == 0) begin
                    checkVal("sbUnderflow", 64'(sb.size()), 1);
                end else begin
                    logic [31:0] p;
                    p = sb.pop_front();
                    checkVal("instrPc", 64'(bus.instr_pc), 64'(p));
                    checkVal("instrData", 64'(bus.instr), 64'(romWord(p)));
                    delivered++;
                end
            end
            holdValid = bus.instr_vld & ~bus.instr_rdy & ~bus.redirect;
            holdPc    = bus.instr_pc;
        end else begin
            holdValid = 1'b0;
        end
    end

    task automatic doReset(input int lat);
        rst    = 1'b0;
        romLat = lat;
        #1;
        checkVal("rstAddrVld", 64'(bus.im_addr_vld), 0);
        checkVal("rstInstrVld", 64'(bus.instr_vld), 0);
        checkVal("rstAddr", 64'(bus.im_addr), 64'(RESET_PC));
        fillSb(RESET_PC);
        expReq   = RESET_PC;
        inflight = 0;
        repeat (2) cycle();
    endtask

    task automatic doRedirect(input logic [31:0] pc);
        expKill         = inflight - int'(bus.im_data_vld);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        fillSb(pc);
        expReq = pc;
        cycle();
        bus.redirect = 1'b0;
        checkVal("killCnt", 64'(dut.killCnt), 64'(expKill));
        checkVal("flushVld", 64'(bus.instr_vld), 0);
    endtask

    task automatic waitDeliver(input string tag, input int n, input int budget);
        int start;
        int i;
        start = delivered;
        i = 0;
        while ((delivered - start) < n && i < budget) begin
            cycle();
            i++;
        end
        checkVal(tag, 64'((delivered - start) >= n), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL globalTimeout: simulation did not finish, compared %0d", compared);
        $fatal(1);
    end

    initial begin
        int r0;
        int d0;
        int i;
        bus.instr_rdy   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // L=1 streaming: one request and one delivery per cycle.
        doReset(1);
        rst = 1'b1;
        #1;
        checkVal("firstReqVld", 64'(bus.im_addr_vld), 1);
        checkVal("firstReqAddr", 64'(bus.im_addr), 64'(RESET_PC));
        waitDeliver("l1Start", 5, 20);
        r0 = reqCount;
        d0 = delivered;
        repeat (10) cycle();
        checkVal("l1ReqRate", 64'(reqCount - r0), 10);
        checkVal("l1DelRate", 64'(delivered - d0), 10);

        // L=3 with a stalled consumer: exactly DEPTH requests, then fill and drain.
        bus.instr_rdy = 1'b0;
        doReset(3);
        r0 = reqCount;
        rst = 1'b1;
        repeat (12) cycle();
        checkVal("stallReqs", 64'(reqCount - r0), 4);
        checkVal("stallAddrVld", 64'(bus.im_addr_vld), 0);
        checkVal("stallInstrVld", 64'(bus.instr_vld), 1);
        checkVal("stallHeadPc", 64'(bus.instr_pc), 0);
        checkVal("stallFifoFull", 64'(dut.fifoCount), 64'(DEPTH));
        bus.instr_rdy = 1'b1;
        i = 0;
        while (!bus.im_addr_vld && i < 10) begin
            cycle();
            i++;
        end
        checkVal("resumeVld", 64'(bus.im_addr_vld), 1);
        checkVal("resumeAddr", 64'(bus.im_addr), 32'h10);
        waitDeliver("drain", 6, 30);

        // Redirect with three requests in flight.
        i = 0;
        while (inflight != 3 && i < 20) begin
            cycle();
            i++;
        end
        checkVal("inflight3", 64'(inflight), 3);
        doRedirect(32'h100);
        waitDeliver("redir100", 6, 40);

        // Redirect coinciding with a response arrival and a consumer pop.
        i = 0;
        while (!(bus.im_data_vld && bus.instr_vld && bus.instr_rdy) && i < 20) begin
            cycle();
            i++;
        end
        checkVal("coincide", 64'(bus.im_data_vld && bus.instr_vld), 1);
        doRedirect(32'h200);
        waitDeliver("redir200", 4, 30);

        // Two redirects with one cycle between them.
        doRedirect(32'h40);
        cycle();
        doRedirect(32'h80);
        waitDeliver("redir80", 6, 40);

        // Reset mid-stream while the FIFO holds two entries.
        bus.instr_rdy = 1'b0;
        i = 0;
        while (dut.fifoCount != 2 && i < 20) begin
            cycle();
            i++;
        end
        checkVal("fifoTwo", 64'(dut.fifoCount), 2);
        doReset(3);
        bus.instr_rdy = 1'b1;
        rst = 1'b1;
        waitDeliver("afterRst", 6, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
